calc_param: RTL

//  Parametrised WIDTH-bit calculator: operand registers A/B, four ops (sub/add/mul/div),

---
 rtl/calc_param.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/calc_param.sv
`default_nettype none
// ============================================================================
//  Module      : calc_param
//  Description : WIDTH-bit calculator with A/B operand registers, single-cycle
//                add/sub, multi-cycle shift-add mul and restoring div, result
//                flags and active-low 7-segment decode of the result.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_param #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din_a,
    input  logic [WIDTH-1:0]         din_b,
    input  logic                     ld_a,
    input  logic                     ld_b,
    input  logic [1:0]               op,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic                     ovf,
    output logic                     dz,
    output logic [7*(WIDTH/4)-1:0]   hex
);

    localparam int c_digits = WIDTH / 4;
    localparam int c_cnt_w  = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    localparam logic [1:0] c_op_sub = 2'b00;
    localparam logic [1:0] c_op_add = 2'b01;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_opb;
    logic                   r_is_div;
    logic [2*WIDTH-1:0]     r_prod;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic [WIDTH-1:0]       r_result;
    logic                   r_ovf;
    logic                   r_dz;

    logic [WIDTH:0]         w_add;
    logic [WIDTH:0]         w_sub;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_mul_nxt;
    logic [WIDTH:0]         w_div_diff;
    logic [2*WIDTH-1:0]     w_div_nxt;
    logic [2*WIDTH-1:0]     w_prod_nxt;

    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};

    // r_prod is shared: {partial product, multiplier} for mul, {remainder, quotient} for div
    assign w_mul_sum  = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_opb})
                                  : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    assign w_mul_nxt  = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign w_div_diff = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_opb};
    assign w_div_nxt  = w_div_diff[WIDTH]
                        ? {r_prod[2*WIDTH-2:WIDTH-1], r_prod[WIDTH-2:0], 1'b0}
                        : {w_div_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
    assign w_prod_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (ld_a) r_a <= din_a;
            if (ld_b) r_b <= din_b;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        if (op == c_op_sub) begin
                            r_result <= w_sub[WIDTH-1:0];
                            r_ovf    <= w_sub[WIDTH];
                            r_dz     <= 1'b0;
                            r_done   <= 1'b1;
                        end else if (op == c_op_add) begin
                            r_result <= w_add[WIDTH-1:0];
                            r_ovf    <= w_add[WIDTH];
                            r_dz     <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_prod   <= {{WIDTH{1'b0}}, r_a};
                            r_opb    <= r_b;
                            r_is_div <= op[0];
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_prod <= w_prod_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_is_div) begin
                            r_ovf <= 1'b0;
                            if (r_opb == '0) begin
                                r_result <= '1;
                                r_dz     <= 1'b1;
                            end else begin
                                r_result <= w_prod_nxt[WIDTH-1:0];
                                r_dz     <= 1'b0;
                            end
                        end else begin
                            r_result <= w_prod_nxt[WIDTH-1:0];
                            r_ovf    <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                            r_dz     <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign ovf    = r_ovf;
    assign dz     = r_dz;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    for (genvar g = 0; g < c_digits; g++) begin : g_hex
        assign hex[7*g +: 7] = seg7(r_result[4*g +: 4]);
    end

endmodule
`default_nettype wire
